// File: rtl/pe_bus_feeder.sv
// pe_bus_feeder: multi-channel ramp stream generator driving PE load ports
module pe_bus_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] cfg_start_val,
  input  logic [NUM_CH*CNT_WIDTH-1:0]  cfg_len,
  input  logic [NUM_CH*CNT_WIDTH-1:0]  cfg_burst,
  input  logic [NUM_CH*CNT_WIDTH-1:0]  cfg_gap,
  input  logic [NUM_CH-1:0]            pe_full,
  output logic [NUM_CH-1:0]            start_pulse,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_en,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic                         all_idle
);
  typedef enum logic [2:0] {IDLE, START, XFER, GAP, DONE} state_t;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                state;
    logic [DATA_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0]  rem, bcnt, gcnt, burst, gap;
    logic [CNT_WIDTH-1:0]  bnext;
    logic                  burst_end;
    assign bnext     = bcnt + CNT_WIDTH'(1);
    assign burst_end = (burst != '0) && (bnext == burst);
    // per-channel sequencer: capture config, pulse start, stream words with optional burst gaps
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        data  <= '0;
        rem   <= '0;
        bcnt  <= '0;
        gcnt  <= '0;
        burst <= '0;
        gap   <= '0;
      end else begin
        case (state)
          IDLE: if (start[i]) begin
            data  <= cfg_start_val[i*DATA_WIDTH +: DATA_WIDTH];
            rem   <= cfg_len[i*CNT_WIDTH +: CNT_WIDTH];
            burst <= cfg_burst[i*CNT_WIDTH +: CNT_WIDTH];
            gap   <= cfg_gap[i*CNT_WIDTH +: CNT_WIDTH];
            bcnt  <= '0;
            state <= START;
          end
          START: state <= (rem == '0) ? DONE : XFER;
          XFER: if (!pe_full[i]) begin
            data <= data + DATA_WIDTH'(1);
            rem  <= rem - CNT_WIDTH'(1);
            bcnt <= burst_end ? '0 : bnext;
            if (rem == CNT_WIDTH'(1)) state <= DONE;
            else if (burst_end && gap != '0) begin
              state <= GAP;
              gcnt  <= gap;
            end
          end
          GAP: begin
            gcnt <= gcnt - CNT_WIDTH'(1);
            if (gcnt == CNT_WIDTH'(1)) state <= XFER;
          end
          default: state <= IDLE;
        endcase
      end
    end
    assign start_pulse[i]                         = state == START;
    assign data_en[i]                             = (state == XFER) && !pe_full[i];
    assign busy[i]                                = state != IDLE;
    assign done[i]                                = state == DONE;
    assign data_out[i*DATA_WIDTH +: DATA_WIDTH]   = data;
  end
  assign all_idle = ~|busy;
endmodule

// File: tb/tb_pe_bus_feeder.sv
// tb_pe_bus_feeder: directed and randomized checks of pe_bus_feeder against a word-count model
module tb_pe_bus_feeder;
  logic clk = 0, rst_n = 0;
  logic [2:0]  start = '0, pe_full = '0;
  logic [47:0] cfg_start_val = '0;
  logic [23:0] cfg_len = '0, cfg_burst = '0, cfg_gap = '0;
  logic [2:0]  start_pulse, data_en, busy, done;
  logic [47:0] data_out;
  logic        all_idle;
  int checks = 0, errors = 0;
  int ph[3], sent[3], gl[3], ln[3], bu[3], ga[3];
  logic [15:0] sv[3], md[3];
  localparam logic [60:0] RST_VEC = 61'(1) << 48;
  wire [60:0] act = {start_pulse, data_en, busy, done, all_idle, data_out};

  always #5 clk = ~clk;

  pe_bus_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_start_val(cfg_start_val),
    .cfg_len(cfg_len), .cfg_burst(cfg_burst), .cfg_gap(cfg_gap), .pe_full(pe_full),
    .start_pulse(start_pulse), .data_out(data_out), .data_en(data_en),
    .busy(busy), .done(done), .all_idle(all_idle)
  );

  // reference: phase 0 idle, 1 start, 2 streaming, 3 gap, 4 done; data = start value + words sent
  always @(posedge clk or negedge rst_n)
    for (int c = 0; c < 3; c++)
      if (!rst_n) begin
        ph[c] = 0;
        md[c] = '0;
      end else
        case (ph[c])
          0: if (start[c]) begin
            sv[c] = cfg_start_val[c*16 +: 16];
            ln[c] = int'(cfg_len[c*8 +: 8]);
            bu[c] = int'(cfg_burst[c*8 +: 8]);
            ga[c] = int'(cfg_gap[c*8 +: 8]);
            sent[c] = 0;
            md[c] = sv[c];
            ph[c] = 1;
          end
          1: ph[c] = (ln[c] == 0) ? 4 : 2;
          2: if (!pe_full[c]) begin
            sent[c]++;
            md[c] = sv[c] + 16'(sent[c]);
            if (sent[c] == ln[c]) ph[c] = 4;
            else if (bu[c] != 0 && sent[c] % bu[c] == 0 && ga[c] != 0) begin
              ph[c] = 3;
              gl[c] = ga[c];
            end
          end
          3: begin
            gl[c]--;
            if (gl[c] == 0) ph[c] = 2;
          end
          default: ph[c] = 0;
        endcase

  function automatic logic [60:0] exp_vec();
    logic [2:0] sp, en, bz, dn;
    logic [47:0] d;
    for (int c = 0; c < 3; c++) begin
      sp[c] = ph[c] == 1;
      en[c] = ph[c] == 2 && !pe_full[c];
      bz[c] = ph[c] != 0;
      dn[c] = ph[c] == 4;
      d[c*16 +: 16] = md[c];
    end
    return {sp, en, bz, dn, ~|bz, d};
  endfunction

  task automatic set_cfg(input int c, input logic [15:0] s, input int l, input int b, input int g);
    cfg_start_val[c*16 +: 16] = s;
    cfg_len[c*8 +: 8]   = 8'(l);
    cfg_burst[c*8 +: 8] = 8'(b);
    cfg_gap[c*8 +: 8]   = 8'(g);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    if (act !== RST_VEC) begin errors++; $display("FAIL reset_state got=%h exp=%h", act, RST_VEC); end
    checks++;
    if (act !== exp_vec()) begin errors++; $display("FAIL reset_model got=%h exp=%h", act, exp_vec()); end
    checks++;
    rst_n = 1;
  endtask

  task automatic test_ramp();
    int n = 0;
    logic [15:0] nx = 16'd1;
    set_cfg(0, 16'd1, 6, 0, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = (k == 0) ? 3'b001 : 3'b000;
      #1;
      if (act !== exp_vec()) begin errors++; $display("FAIL ramp_cycle k=%0d got=%h exp=%h", k, act, exp_vec()); end
      checks++;
      if (data_en[0]) begin
        if (data_out[15:0] !== nx) begin errors++; $display("FAIL ramp_word got=%h exp=%h", data_out[15:0], nx); end
        checks++;
        nx++;
        n++;
      end
    end
    if (n != 6) begin errors++; $display("FAIL ramp_count got=%0d exp=6", n); end
    checks++;
  endtask

  task automatic test_burst();
    int n = 0, gaps = 0;
    logic [15:0] nx = 16'd1;
    set_cfg(1, 16'd1, 36, 9, 10);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      start = (k == 0) ? 3'b010 : 3'b000;
      #1;
      if (act !== exp_vec()) begin errors++; $display("FAIL burst_cycle k=%0d got=%h exp=%h", k, act, exp_vec()); end
      checks++;
      if (busy[1] && !data_en[1] && !start_pulse[1] && !done[1]) gaps++;
      if (data_en[1]) begin
        if (data_out[31:16] !== nx) begin errors++; $display("FAIL burst_word got=%h exp=%h", data_out[31:16], nx); end
        checks++;
        nx++;
        n++;
      end
    end
    if (n != 36 || gaps != 30) begin errors++; $display("FAIL burst_shape words=%0d gaps=%0d exp=36/30", n, gaps); end
    checks++;
  endtask

  task automatic test_backpressure();
    int n = 0, held = 0, stalls = 0;
    logic [15:0] nx = 16'd1;
    set_cfg(0, 16'd1, 6, 0, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k == 0) ? 3'b001 : 3'b000;
      pe_full[0] = (n == 2 && held < 3);
      if (pe_full[0]) held++;
      #1;
      if (act !== exp_vec()) begin errors++; $display("FAIL bp_cycle k=%0d got=%h exp=%h", k, act, exp_vec()); end
      checks++;
      if (busy[0] && pe_full[0] && !data_en[0]) stalls++;
      if (data_en[0]) begin
        if (data_out[15:0] !== nx) begin errors++; $display("FAIL bp_word got=%h exp=%h", data_out[15:0], nx); end
        checks++;
        nx++;
        n++;
      end
    end
    pe_full = '0;
    if (n != 6 || stalls != 3) begin errors++; $display("FAIL bp_shape words=%0d stalls=%0d exp=6/3", n, stalls); end
    checks++;
  endtask

  task automatic test_multi();
    int en0 = 0, done2_k = -1, idle_k = -1, done0_k = -1;
    set_cfg(0, 16'd100, 0, 0, 0);
    set_cfg(1, 16'd200, 2, 0, 0);
    set_cfg(2, 16'd300, 3, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k == 0) ? 3'b111 : 3'b000;
      #1;
      if (act !== exp_vec()) begin errors++; $display("FAIL multi_cycle k=%0d got=%h exp=%h", k, act, exp_vec()); end
      checks++;
      if (k == 1 && start_pulse !== 3'b111) begin errors++; $display("FAIL multi_pulse got=%b exp=111", start_pulse); end
      if (k == 1) checks++;
      if (data_en[0]) en0++;
      if (done[0] && done0_k < 0) done0_k = k;
      if (done[2] && done2_k < 0) done2_k = k;
      if (k > 1 && all_idle && idle_k < 0) idle_k = k;
    end
    if (en0 != 0 || done0_k != 2) begin errors++; $display("FAIL multi_len0 en=%0d done_k=%0d exp=0/2", en0, done0_k); end
    checks++;
    if (done2_k != 5 || idle_k != 6) begin errors++; $display("FAIL multi_idle done2=%0d idle=%0d exp=5/6", done2_k, idle_k); end
    checks++;
  endtask

  task automatic test_wrap();
    int n = 0, pulses = 0;
    logic [15:0] nx = 16'hFFFE;
    set_cfg(0, 16'hFFFE, 4, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k == 0 || k == 3) ? 3'b001 : 3'b000;
      if (k == 3) set_cfg(0, 16'h1234, 9, 2, 2);
      #1;
      if (act !== exp_vec()) begin errors++; $display("FAIL wrap_cycle k=%0d got=%h exp=%h", k, act, exp_vec()); end
      checks++;
      if (start_pulse[0]) pulses++;
      if (data_en[0]) begin
        if (data_out[15:0] !== nx) begin errors++; $display("FAIL wrap_word got=%h exp=%h", data_out[15:0], nx); end
        checks++;
        nx++;
        n++;
      end
    end
    if (n != 4 || pulses != 1) begin errors++; $display("FAIL wrap_shape words=%0d pulses=%0d exp=4/1", n, pulses); end
    checks++;
  endtask

  task automatic test_reset_mid();
    set_cfg(1, 16'd1, 36, 9, 10);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k == 0) ? 3'b010 : 3'b000;
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    if (act !== RST_VEC) begin errors++; $display("FAIL reset_mid got=%h exp=%h", act, RST_VEC); end
    checks++;
    @(negedge clk);
    if (done !== 3'b000) begin errors++; $display("FAIL reset_mid_done got=%b exp=000", done); end
    checks++;
    rst_n = 1;
    test_burst();
  endtask

  task automatic test_random();
    int waited = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        set_cfg(c, 16'($urandom), $urandom_range(0, 10), $urandom_range(0, 4), $urandom_range(0, 3));
        start[c]   = ($urandom_range(0, 3) == 0);
        pe_full[c] = ($urandom_range(0, 2) == 0);
      end
      #1;
      if (act !== exp_vec()) begin errors++; $display("FAIL random_cycle k=%0d got=%h exp=%h", k, act, exp_vec()); end
      checks++;
    end
    @(negedge clk);
    start = '0;
    pe_full = '0;
    while (!all_idle && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!all_idle) begin errors++; $display("FAIL random_drain all_idle=%b exp=1", all_idle); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_burst();
    test_backpressure();
    test_multi();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
